// File: rtl/shift_stage_skid_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_stage_skid_pkg
//  Purpose  : Shared widths and control-state encoding for the registered
//             skid stage that follows the shift16 stage of the barrel shifter.
//  Revision : 1.0  initial release
// ============================================================================
package shift_stage_skid_pkg;

  localparam int DEF_DW = 32;  // stage output word width
  localparam int DEF_RW = 4;   // residual shift bits S[3:0]
  localparam int DEF_TW = 4;   // opaque tag width

  // Number of held entries doubles as the state code, so occ is the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_stage_skid_if.sv
`default_nettype none
// ============================================================================
//  Module   : shift_stage_skid_if
//  Purpose  : Valid/ready stream carrying shifted word, residual shift and tag.
//  Revision : 1.0  initial release
// ============================================================================
interface shift_stage_skid_if
  import shift_stage_skid_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int RW = DEF_RW,
  parameter int TW = DEF_TW
) ();

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic [RW-1:0] rsh;
  logic [TW-1:0] tag;

  // Producer side drives payload and valid, consumer answers with ready.
  modport master (output valid, output data, output rsh, output tag, input ready);
  modport slave  (input valid, input data, input rsh, input tag, output ready);

endinterface
`default_nettype wire

// File: rtl/shift_stage_skid_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_stage_skid_pipe_reg
//  Purpose  : Enable-loaded flop bank with asynchronous active-low clear.
//             Used as both the main and the skid entry of the stage.
//  Revision : 1.0  initial release
// ============================================================================
module shift_stage_skid_pipe_reg #(
  parameter int W = 40
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         en,
  input  wire logic [W-1:0] d,
  output logic      [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // Hold the current contents unless a load is requested.
  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  // Storage; cleared to zero on reset so downstream sees a defined word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule
`default_nettype wire

// File: rtl/shift_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : shift_stage_skid
//  Purpose  : Registered stage after the shift16 stage. Two-entry skid buffer
//             (main + skid) so that in_ready comes straight from a flop.
//  Options  : PARITY_CHK_EN - store even parity of each accepted word and flag
//             par_err when the presented word no longer matches it.
//  Revision : 1.0  initial release
// ============================================================================
module shift_stage_skid
  import shift_stage_skid_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int RW = DEF_RW,
  parameter int TW = DEF_TW
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  input  wire logic           flush,
  shift_stage_skid_if.slave   in_s,
  shift_stage_skid_if.master  out_m,
  output logic [1:0]          occ,
  output logic                par_err
);

`ifdef PARITY_CHK_EN
  localparam int EW = DW + RW + TW + 1;
`else
  localparam int EW = DW + RW + TW;
`endif

  state_t        state_d, state_q;
  logic          in_ready_d, in_ready_q;
  logic          accept, send, out_valid;
  logic          main_en, main_from_skid, skid_en;
  logic [EW-1:0] in_entry, main_d, main_q, skid_q;

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_s.valid & in_ready_q;
  assign send      = out_valid & out_m.ready;

`ifdef PARITY_CHK_EN
  // Parity bit sits on top so the payload field positions match both builds.
  assign in_entry = {^in_s.data, in_s.data, in_s.rsh, in_s.tag};
  assign par_err  = out_valid & ((^main_q[RW+TW +: DW]) != main_q[EW-1]);
`else
  assign in_entry = {in_s.data, in_s.rsh, in_s.tag};
  assign par_err  = 1'b0;
`endif

  // Control: next state, register loads and the next value of in_ready.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_en = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !send) begin
          state_d = ST_TWO;
          skid_en = 1'b1;
        end else if (send && !accept) begin
          state_d = ST_EMPTY;
        end else if (accept && send) begin
          main_en = 1'b1;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the drain of main can happen.
        if (send) begin
          state_d        = ST_ONE;
          main_en        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over everything, including a word accepted this cycle.
    if (flush) begin
      state_d = ST_EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
    in_ready_d = (state_d != ST_TWO);
  end

  // State and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_entry;

  shift_stage_skid_pipe_reg #(.W(EW)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  shift_stage_skid_pipe_reg #(.W(EW)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (in_entry),
    .q     (skid_q)
  );

  assign in_s.ready = in_ready_q;
  assign out_m.valid = out_valid;
  assign out_m.data  = main_q[RW+TW +: DW];
  assign out_m.rsh   = main_q[TW +: RW];
  assign out_m.tag   = main_q[0 +: TW];
  assign occ         = state_q;

endmodule
`default_nettype wire
